// File: rtl/ctrl_path_pipe_if.sv
// Control-path bundle between ctrl_path_pipe and the datapath.
// CTRL_ILLEGAL_TRAP_EN adds the IllegalW flag.
interface ctrl_path_pipe_if #(
  parameter int unsigned ALUCTL_W = 4
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                ZeroE;
  logic                LtE;
  logic                LtuE;
  logic                StallE;
  logic                FlushE;
  logic [2:0]          ImmSrcD;
  logic                ALUSrcAE;
  logic [1:0]          ALUSrcBE;
  logic [ALUCTL_W-1:0] ALUControlE;
  logic                PCSrcE;
  logic                PCJalSrcE;
  logic                ResultSrcE0;
  logic                MemWriteM;
  logic                RegWriteM;
  logic                RegWriteW;
  logic [1:0]          ResultSrcW;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                IllegalW;
`endif

  modport master (
    input  opcode, funct3, funct7, ZeroE, LtE, LtuE, StallE, FlushE,
    output ImmSrcD, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, PCJalSrcE, ResultSrcE0,
    output MemWriteM, RegWriteM, RegWriteW, ResultSrcW
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output IllegalW
`endif
  );

  modport slave (
    output opcode, funct3, funct7, ZeroE, LtE, LtuE, StallE, FlushE,
    input  ImmSrcD, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, PCJalSrcE, ResultSrcE0,
    input  MemWriteM, RegWriteM, RegWriteW, ResultSrcW
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input IllegalW
`endif
  );
endinterface

// File: rtl/ctrl_path_pipe.sv
// Pipelined RV32I control path: decode in D, branch/jump resolution in E, MEM_STAGES to W.
// Define CTRL_ILLEGAL_TRAP_EN to flag illegal opcodes on IllegalW.
module ctrl_path_pipe #(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned ALUCTL_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  ctrl_path_pipe_if.master bus
);
  localparam logic [3:0] AluAdd  = 4'd0,  AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4,  AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8,  AluAnd = 4'd9, AluPassB = 4'd10;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       br;
    logic       jump;
    logic       jalr;
    logic       a;
    logic [1:0] b;
    logic [1:0] res;
    logic [3:0] alu;
    logic [2:0] f3;
  } ctrl_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  ctrl_t                       ctl_d, ex_q;
  logic [2:0]                  imm_d;
  logic                        cond;
  logic                        mem_bubble;
  logic                        mw_m_q;
  logic [MEM_STAGES-1:0]       rw_m_q;
  logic [MEM_STAGES-1:0][1:0]  res_m_q;
  logic                        rw_w_q;
  logic [1:0]                  res_w_q;
  logic                        unused_funct7;

  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  always_comb begin
    ctl_d    = '0;
    ctl_d.f3 = bus.funct3;
    imm_d    = 3'b000;
    case (bus.opcode)
      7'b0110011: begin
        ctl_d.rw  = 1'b1;
        ctl_d.alu = alu_op(bus.funct3, bus.funct7[5]);
      end
      7'b0010011: begin
        ctl_d.rw  = 1'b1;
        ctl_d.b   = 2'b01;
        // Only srai uses funct7[5]; other immediates may have that bit set.
        ctl_d.alu = alu_op(bus.funct3, (bus.funct3 == 3'b101) & bus.funct7[5]);
      end
      7'b0000011: begin
        ctl_d.rw = 1'b1; ctl_d.b = 2'b01; ctl_d.res = 2'b01; ctl_d.alu = AluAdd;
      end
      7'b0100011: begin
        ctl_d.mw = 1'b1; ctl_d.b = 2'b01; imm_d = 3'b001; ctl_d.alu = AluAdd;
      end
      7'b1100011: begin
        ctl_d.br = 1'b1; imm_d = 3'b010; ctl_d.alu = AluSub;
      end
      7'b1101111: begin
        ctl_d.rw = 1'b1; ctl_d.jump = 1'b1; imm_d = 3'b011; ctl_d.res = 2'b10;
      end
      7'b1100111: begin
        ctl_d.rw = 1'b1; ctl_d.jump = 1'b1; ctl_d.jalr = 1'b1; ctl_d.b = 2'b01;
        ctl_d.res = 2'b10; ctl_d.alu = AluAdd;
      end
      7'b0110111: begin
        ctl_d.rw = 1'b1; ctl_d.b = 2'b01; imm_d = 3'b100; ctl_d.alu = AluPassB;
      end
      7'b0010111: begin
        ctl_d.rw = 1'b1; ctl_d.a = 1'b1; ctl_d.b = 2'b01; imm_d = 3'b100; ctl_d.alu = AluAdd;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ex_q.f3)
      3'b000:  cond = bus.ZeroE;
      3'b001:  cond = ~bus.ZeroE;
      3'b100:  cond = bus.LtE;
      3'b101:  cond = ~bus.LtE;
      3'b110:  cond = bus.LtuE;
      3'b111:  cond = ~bus.LtuE;
      default: cond = 1'b0;
    endcase
  end

  // A held E slot must not also advance, otherwise its write/store would repeat.
  assign mem_bubble = bus.StallE & ~bus.FlushE;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mw_m_q  <= 1'b0;
      rw_m_q  <= '0;
      res_m_q <= '0;
      rw_w_q  <= 1'b0;
      res_w_q <= 2'b00;
    end else begin
      if (bus.FlushE) begin
        ex_q <= '0;
      end else if (!bus.StallE) begin
        ex_q <= ctl_d;
      end
      mw_m_q     <= ex_q.mw & ~mem_bubble;
      rw_m_q[0]  <= ex_q.rw & ~mem_bubble;
      res_m_q[0] <= mem_bubble ? 2'b00 : ex_q.res;
      for (int i = 1; i < MEM_STAGES; i++) begin
        rw_m_q[i]  <= rw_m_q[i-1];
        res_m_q[i] <= res_m_q[i-1];
      end
      rw_w_q  <= rw_m_q[MEM_STAGES-1];
      res_w_q <= res_m_q[MEM_STAGES-1];
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                  ill_d;
  logic                  ill_e_q;
  logic [MEM_STAGES-1:0] ill_m_q;
  logic                  ill_w_q;

  // Every legal opcode sets at least one of RegWrite, MemWrite or Branch.
  assign ill_d = ~(ctl_d.rw | ctl_d.mw | ctl_d.br);

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_e_q <= 1'b0;
      ill_m_q <= '0;
      ill_w_q <= 1'b0;
    end else begin
      if (bus.FlushE) begin
        ill_e_q <= 1'b0;
      end else if (!bus.StallE) begin
        ill_e_q <= ill_d;
      end
      ill_m_q[0] <= ill_e_q & ~mem_bubble;
      for (int i = 1; i < MEM_STAGES; i++) begin
        ill_m_q[i] <= ill_m_q[i-1];
      end
      ill_w_q <= ill_m_q[MEM_STAGES-1];
    end
  end

  assign bus.IllegalW = ill_w_q;
`endif

  assign bus.ImmSrcD     = imm_d;
  assign bus.ALUSrcAE    = ex_q.a;
  assign bus.ALUSrcBE    = ex_q.b;
  assign bus.ALUControlE = ALUCTL_W'(ex_q.alu);
  assign bus.PCSrcE      = (ex_q.br & cond) | ex_q.jump;
  assign bus.PCJalSrcE   = ex_q.jalr;
  assign bus.ResultSrcE0 = ex_q.res[0];
  assign bus.MemWriteM   = mw_m_q;
  assign bus.RegWriteM   = rw_m_q[0];
  assign bus.RegWriteW   = rw_w_q;
  assign bus.ResultSrcW  = res_w_q;
endmodule

// File: tb/tb_ctrl_path_pipe.sv
// Directed bench for ctrl_path_pipe with MEM_STAGES=2; trap checks under CTRL_ILLEGAL_TRAP_EN.
module tb_ctrl_path_pipe;
  localparam int unsigned MS = 2;
  localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011, OpL = 7'b0000011;
  localparam logic [6:0] OpS = 7'b0100011, OpB = 7'b1100011, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpLui = 7'b0110111, OpAuipc = 7'b0010111;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ctrl_path_pipe_if #(.ALUCTL_W(4)) bus ();

  ctrl_path_pipe #(.MEM_STAGES(MS), .ALUCTL_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  logic [6:0] tab_op  [6];
  logic [2:0] tab_f3  [6];
  logic [6:0] tab_f7  [6];
  logic [3:0] tab_alu [6];

  initial begin
    tab_op[0] = OpR; tab_f3[0] = 3'b000; tab_f7[0] = 7'h20; tab_alu[0] = 4'd1;
    tab_op[1] = OpR; tab_f3[1] = 3'b101; tab_f7[1] = 7'h20; tab_alu[1] = 4'd7;
    tab_op[2] = OpR; tab_f3[2] = 3'b011; tab_f7[2] = 7'h00; tab_alu[2] = 4'd4;
    tab_op[3] = OpI; tab_f3[3] = 3'b000; tab_f7[3] = 7'h20; tab_alu[3] = 4'd0;
    tab_op[4] = OpI; tab_f3[4] = 3'b101; tab_f7[4] = 7'h20; tab_alu[4] = 4'd7;
    tab_op[5] = OpI; tab_f3[5] = 3'b110; tab_f7[5] = 7'h20; tab_alu[5] = 4'd8;

    reset = 1'b1;
    drive(OpI, 3'b000, 7'h00);
    bus.ZeroE = 1'b0; bus.LtE = 1'b0; bus.LtuE = 1'b0;
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    tick();
    chk("rst_pcsrc",   32'(bus.PCSrcE),      0);
    chk("rst_jal",     32'(bus.PCJalSrcE),   0);
    chk("rst_srca",    32'(bus.ALUSrcAE),    0);
    chk("rst_srcb",    32'(bus.ALUSrcBE),    0);
    chk("rst_aluctl",  32'(bus.ALUControlE), 0);
    chk("rst_load",    32'(bus.ResultSrcE0), 0);
    chk("rst_memw",    32'(bus.MemWriteM),   0);
    chk("rst_regwm",   32'(bus.RegWriteM),   0);
    chk("rst_regww",   32'(bus.RegWriteW),   0);
    chk("rst_resw",    32'(bus.ResultSrcW),  0);
    reset = 1'b0;

    drive(OpS, 3'b010, 7'h00);   #1 chk("imm_s",   32'(bus.ImmSrcD), 1);
    drive(OpB, 3'b001, 7'h00);   #1 chk("imm_b",   32'(bus.ImmSrcD), 2);
    drive(OpJal, 3'b000, 7'h00); #1 chk("imm_j",   32'(bus.ImmSrcD), 3);
    drive(OpLui, 3'b000, 7'h00); #1 chk("imm_u",   32'(bus.ImmSrcD), 4);

    // BNE
    drive(OpB, 3'b001, 7'h00);
    tick();
    chk("bne_taken", 32'(bus.PCSrcE), 1);
    chk("bne_alu",   32'(bus.ALUControlE), 1);
    chk("bne_srcb",  32'(bus.ALUSrcBE), 0);
    bus.ZeroE = 1'b1; #1 chk("bne_zero", 32'(bus.PCSrcE), 0);
    bus.ZeroE = 1'b0; bus.funct3 = 3'b000; #1 chk("bne_d_f3_change", 32'(bus.PCSrcE), 1);

    // BLTU, BGE, and never-taken funct3 010
    drive(OpB, 3'b110, 7'h00);
    tick();
    bus.LtuE = 1'b1; bus.LtE = 1'b0; #1 chk("bltu_taken", 32'(bus.PCSrcE), 1);
    drive(OpB, 3'b101, 7'h00);
    tick();
    bus.LtE = 1'b1; bus.LtuE = 1'b0; #1 chk("bge_lt", 32'(bus.PCSrcE), 0);
    bus.LtE = 1'b0; #1 chk("bge_ge", 32'(bus.PCSrcE), 1);
    drive(OpB, 3'b010, 7'h00);
    tick();
    bus.ZeroE = 1'b1; bus.LtE = 1'b1; bus.LtuE = 1'b1;
    #1 chk("br_f3_010", 32'(bus.PCSrcE), 0);
    bus.ZeroE = 1'b0; bus.LtE = 1'b0; bus.LtuE = 1'b0;

    // LW: E to W is MS+1 cycles
    drive(OpL, 3'b010, 7'h00);
    tick();
    chk("lw_e_load", 32'(bus.ResultSrcE0), 1);
    chk("lw_e_alu",  32'(bus.ALUControlE), 0);
    chk("lw_e_srcb", 32'(bus.ALUSrcBE), 1);
    drive(OpI, 3'b000, 7'h00);
    tick();
    chk("lw_m_regw", 32'(bus.RegWriteM), 1);
    chk("lw_m_memw", 32'(bus.MemWriteM), 0);
    for (int i = 1; i < MS; i++) tick();
    chk("lw_w_early", 32'(bus.RegWriteW), 0);
    tick();
    chk("lw_w_regw", 32'(bus.RegWriteW), 1);
    chk("lw_w_res",  32'(bus.ResultSrcW), 1);
    tick();
    chk("lw_w_after", 32'(bus.ResultSrcW), 0);

    // SW held in E for two stall cycles
    drive(OpS, 3'b010, 7'h00);
    tick();
    chk("sw_e_memw", 32'(bus.MemWriteM), 0);
    chk("sw_e_srcb", 32'(bus.ALUSrcBE), 1);
    drive(OpI, 3'b000, 7'h00);
    bus.StallE = 1'b1;
    tick();
    chk("sw_stall1_memw", 32'(bus.MemWriteM), 0);
    chk("sw_stall1_regw", 32'(bus.RegWriteM), 0);
    chk("sw_stall1_hold", 32'(bus.ALUSrcBE), 1);
    tick();
    chk("sw_stall2_memw", 32'(bus.MemWriteM), 0);
    bus.StallE = 1'b0;
    tick();
    chk("sw_m_memw", 32'(bus.MemWriteM), 1);
    chk("sw_m_regw", 32'(bus.RegWriteM), 0);
    tick();
    chk("sw_after_memw", 32'(bus.MemWriteM), 0);

    // JALR then flush+stall together
    drive(OpJalr, 3'b000, 7'h00);
    tick();
    chk("jalr_pcsrc",  32'(bus.PCSrcE), 1);
    chk("jalr_jalsrc", 32'(bus.PCJalSrcE), 1);
    chk("jalr_srcb",   32'(bus.ALUSrcBE), 1);
    drive(OpI, 3'b000, 7'h00);
    bus.FlushE = 1'b1; bus.StallE = 1'b1;
    tick();
    chk("flush_pcsrc",  32'(bus.PCSrcE), 0);
    chk("flush_jalsrc", 32'(bus.PCJalSrcE), 0);
    chk("flush_m_regw", 32'(bus.RegWriteM), 1);
    bus.FlushE = 1'b0; bus.StallE = 1'b0;
    for (int i = 0; i < MS; i++) tick();
    chk("jalr_w_res",  32'(bus.ResultSrcW), 2);
    chk("jalr_w_regw", 32'(bus.RegWriteW), 1);

    drive(OpJal, 3'b000, 7'h00);
    tick();
    chk("jal_pcsrc",  32'(bus.PCSrcE), 1);
    chk("jal_jalsrc", 32'(bus.PCJalSrcE), 0);
    chk("jal_srca",   32'(bus.ALUSrcAE), 0);
    drive(OpAuipc, 3'b000, 7'h00);
    tick();
    chk("auipc_srca",  32'(bus.ALUSrcAE), 1);
    chk("auipc_srcb",  32'(bus.ALUSrcBE), 1);
    chk("auipc_alu",   32'(bus.ALUControlE), 0);
    chk("auipc_pcsrc", 32'(bus.PCSrcE), 0);
    drive(OpLui, 3'b000, 7'h00);
    tick();
    chk("lui_alu", 32'(bus.ALUControlE), 10);

    for (int i = 0; i < 6; i++) begin
      drive(tab_op[i], tab_f3[i], tab_f7[i]);
      tick();
      chk($sformatf("alu_tab%0d", i), 32'(bus.ALUControlE), 32'(tab_alu[i]));
    end

    // Illegal opcode
    drive(7'h7f, 3'b000, 7'h00);
    tick();
    chk("ill_e_pcsrc", 32'(bus.PCSrcE), 0);
    chk("ill_e_alu",   32'(bus.ALUControlE), 0);
    drive(OpI, 3'b000, 7'h00);
    tick();
    chk("ill_m_regw", 32'(bus.RegWriteM), 0);
    for (int i = 1; i < MS; i++) tick();
    tick();
    chk("ill_w_regw", 32'(bus.RegWriteW), 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_w_flag", 32'(bus.IllegalW), 1);
`endif
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_w_pulse", 32'(bus.IllegalW), 0);
`endif
    chk("ill_w_next_regw", 32'(bus.RegWriteW), 1);

    // Reset with LW in MEM and SW in E
    drive(OpL, 3'b010, 7'h00);
    tick();
    drive(OpS, 3'b010, 7'h00);
    tick();
    reset = 1'b1;
    drive(OpJal, 3'b000, 7'h00);
    tick();
    chk("mrst_pcsrc",  32'(bus.PCSrcE), 0);
    chk("mrst_srcb",   32'(bus.ALUSrcBE), 0);
    chk("mrst_load",   32'(bus.ResultSrcE0), 0);
    chk("mrst_memw",   32'(bus.MemWriteM), 0);
    chk("mrst_regwm",  32'(bus.RegWriteM), 0);
    chk("mrst_regww",  32'(bus.RegWriteW), 0);
    chk("mrst_resw",   32'(bus.ResultSrcW), 0);
    chk("mrst_imm",    32'(bus.ImmSrcD), 3);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("mrst_ill",    32'(bus.IllegalW), 0);
`endif
    reset = 1'b0;
    tick();
    chk("post_rst_jal", 32'(bus.PCSrcE), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_path_pipe.md
# ctrl_path_pipe

Parametrised pipelined control path for the RV32I core: decodes in D, carries control through ID/EX, a configurable number of MEM stages and MEM/WB, and resolves all six branch conditions plus JAL/JALR in E. Successor to the fixed 5-stage control path. It adds hazard stall/flush inputs, pipelined funct3/JALR so branch resolution uses the E-stage instruction, full signed/unsigned branch compares, and variable memory latency. It sits beside the datapath and drives its muxes, ALU and write enables.

## Interface
- MEM_STAGES, 1, number of register stages between E and W (1..3); 1 gives classic 5-stage
- ALUCTL_W, 4, ALU control width (fixed encoding below, MSBs zero-extended if wider)
- Clocking/reset: one clock; reset is synchronous and active-high.
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous active-high; clears every pipeline register
- opcode  in  7  D-stage instr[6:0]
- funct3  in  3  D-stage instr[14:12]
- funct7  in  7  D-stage instr[31:25]
- ZeroE  in  1  ALU result == 0 (E)
- LtE  in  1  signed rs1 < rs2 (E)
- LtuE  in  1  unsigned rs1 < rs2 (E)
- StallE  in  1  hold ID/EX register
- FlushE  in  1  load bubble into ID/EX
- ImmSrcD  out  3  immediate format, combinational from D
- ALUSrcAE  out  1  0=rs1, 1=PC
- ALUSrcBE  out  2  00=rs2, 01=imm
- ALUControlE  out  ALUCTL_W  ALU op
- PCSrcE  out  1  take branch/jump target
- PCJalSrcE  out  1  target = ALU result (JALR)
- ResultSrcE0  out  1  E instruction is a load, for the load-use hazard unit
- MemWriteM  out  1  store enable, first MEM stage
- RegWriteM  out  1  regwrite of first MEM stage, for forwarding
- RegWriteW  out  1  regfile write enable
- ResultSrcW  out  2  00=ALU, 01=mem, 10=PC+4

## Operation
- Decode by opcode, with RW=RegWrite, MW=MemWrite:
  - R 0110011: RW, B=00
  - I-ALU 0010011: RW, B=01, Imm=000
  - Load 0000011: RW, B=01, Res=01, add
  - Store 0100011: MW, B=01, Imm=001, add
  - Branch 1100011: Br, B=00, Imm=010, sub
  - JAL 1101111: RW, Jump, Imm=011, Res=10
  - JALR 1100111: RW, Jump, Jalr, B=01, Imm=000, Res=10, add
  - LUI 0110111: RW, B=01, Imm=100, passB
  - AUIPC 0010111: RW, A=1, B=01, Imm=100, add
  - any other opcode: illegal, all enables 0
- ALU encoding: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1010 passB.
- ALU op selection: R and I-ALU use funct3. For R, funct7[5] selects sub vs add and sra vs srl. For I, funct7[5] is honoured only for funct3=101 (srai).
- ID/EX carries: RW, MW, Br, Jump, Jalr, A, B, ResultSrc, ALUControl, funct3.
- Branch condition from funct3E: 000 Z, 001 !Z, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu; 010/011 never taken.
- PCSrcE = (BrE & cond) | JumpE. PCJalSrcE = JalrE. Both come from the registered E state only.
- ID/EX update priority: reset > FlushE (bubble: all enables, Br and Jump 0) > StallE (hold) > load from D.
- StallE=1 with FlushE=0: ID/EX holds and the first MEM stage receives a bubble, so no duplicate write or store.
- MEM and MEM/WB stages always advance. RW and ResultSrc shift through MEM_STAGES registers. MW is consumed in the first MEM stage only.

## Timing
- Reset value of every output: 0 (ImmSrcD follows the opcode input). All pipeline registers read 0 one cycle after reset is sampled.
- Reset mid-operation clears every in-flight instruction on the same edge.
- Latency from D to E is 1 cycle. E to MEM-first is 1. E to W is MEM_STAGES+1.
- PCSrcE is combinational from E state and valid in the same cycle the instruction is in E.
- FlushE and StallE asserted together: the flush wins.
- A flushed E slot never asserts PCSrcE.

## Configuration
- CTRL_ILLEGAL_TRAP_EN
  - Defined: adds an output IllegalW (1 bit). An illegal opcode propagates a flag and pulses IllegalW for 1 cycle when it reaches W; flushed and stalled-bubble slots never flag.
  - Undefined: the port is absent, and an illegal opcode is a silent NOP.

## Test plan
- BNE (opcode 1100011, funct3 001) in E with ZeroE=0 -> PCSrcE=1. Same with ZeroE=1 -> 0. Changing D funct3 to 000 in the same cycle does not alter PCSrcE.
- BLTU with LtuE=1, LtE=0 -> PCSrcE=1. BGE with LtE=1 -> 0.
- LW (0000011) with MEM_STAGES=2 -> ResultSrcE0=1 in E, RegWriteW=1 and ResultSrcW=01 exactly 3 cycles after E.
- SW in D, StallE=1 for 2 cycles -> MemWriteM=1 exactly once, with bubbles in the stall cycles.
- JALR in E, FlushE=1 and StallE=1 on the next edge -> E becomes a bubble and PCSrcE=0 the following cycle.
- Opcode 1111111 with CTRL_ILLEGAL_TRAP_EN, MEM_STAGES=1 -> IllegalW=1 two cycles after E, RegWriteW=0. Reset asserted mid-flight -> all outputs 0 after the next edge.
